pio_in_irq: RTL and testbench
=============================

Name: pio_in_irq

Overview:
- Parametrised Avalon-MM slave input port; successor to the fixed 4-bit switch reader.
- Adds configurable width, an input synchroniser, an edge-capture register, a per-bit interrupt mask and a level IRQ output.
- Sits between board-level inputs (switches, keys, limit sensors) and the HPS/Nios bus; one instance per input group.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- SYNC_STAGES, 2, flip-flop synchroniser depth on in_port (2..4).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- DEBOUNCE_CYCLES, 16, stable cycles required before a bit change is accepted (only with the debounce option; >=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  word address of register.
- chipselect  in  1  slave select; qualifies writes.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset (async, active-high): synchroniser chain, data_q, edge_cap, irq_mask, readdata and irq all 0; debounce counters 0.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_in. data_q is sync_in, or the debounced value when the debounce option is built.
- Input latency: an in_port change is visible in data_q after SYNC_STAGES+1 clocks (debounce adds DEBOUNCE_CYCLES).
- Edge detect compares data_q with its one-cycle-delayed copy data_d:
  - rise = data_q & ~data_d
  - fall = ~data_q & data_d
  - EDGE_TYPE selects rise, fall or rise|fall.
- Register map, word addresses; unused readdata bits are 0:
  - 0 DATA: data_q; read-only, writes ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQ_MASK: WIDTH bits, read/write.
  - 3 EDGE_CAP: WIDTH bits; read; writing 1 to a bit clears it, writing 0 has no effect.
- Write accepted when chipselect & write, in a single cycle; no wait states.
- Read timing: readdata is registered every clock from the current address (no read strobe). Read latency is 1 clock.
- Set/clear collision: if a detected edge and a write-1-clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- irq: registered. irq <= |(edge_cap & irq_mask), so it asserts 1 clock after the edge_cap/mask condition becomes true and deasserts 1 clock after it clears.
- Width: writedata[WIDTH-1:0] is used and upper bits are ignored. For WIDTH=32 all bits are live.
- Reset mid-operation: everything clears immediately; no spurious edge is captured on the first cycle after reset, because data_d resets equal to data_q (both 0).

Optional Feature:
- Macro: PIO_IN_DEBOUNCE_EN.
- Defined: each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - While sync_in[i] != stable[i] the counter increments; when it reaches DEBOUNCE_CYCLES, stable[i] <= sync_in[i] and the counter clears.
  - Any cycle with sync_in[i] == stable[i] clears the counter.
  - data_q = stable.
- Undefined: no counters; data_q = sync_in. The DEBOUNCE_CYCLES parameter is present but unused.

Decomposition:
- Package pio_in_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3;
  - edge-type constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One sub-module, pio_in_debounce: one bit, with a parameter for cycle count. It is generate-replicated WIDTH times and only instantiated under PIO_IN_DEBOUNCE_EN.

Test Plan (WIDTH=4, SYNC_STAGES=2, EDGE_TYPE=0, DEBOUNCE_CYCLES=4 where enabled):
1. Reset released, in_port=4'b1010 held, then read addr 0 → readdata=32'h0000000A; EDGE_CAP reads 4'b1010 (rise from reset 0); irq=0 because mask is 0.
2. Write IRQ_MASK=4'b0010, then in_port bit1 0→1 → EDGE_CAP[1]=1 and irq=1 one clock later. Write EDGE_CAP=4'b0010 → EDGE_CAP=0 and irq=0 the clock after.
3. A new rising edge on bit0 arrives in the same cycle as a write EDGE_CAP=4'b0001 → bit0 remains 1.
4. EDGE_TYPE=2, in_port bit3 toggles 1→0→1 → EDGE_CAP[3] sets on both transitions. With EDGE_TYPE=1, only the fall sets it.
5. PIO_IN_DEBOUNCE_EN: bit0 glitches high for 3 cycles → DATA unchanged and no edge. Held high for 6 cycles → DATA[0]=1 after 2+1+4 clocks.
6. Assert reset while irq=1 and EDGE_CAP=4'hF → irq, readdata, EDGE_CAP and IRQ_MASK are all 0 immediately (asynchronously).

Source files
------------

// File: rtl/pio_in_pkg.sv
// Shared constants for the parametrised PIO input port: register word
// addresses and edge-capture type encodings.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// Single-bit debouncer: a change on din is accepted only once it has held
// for CYCLES consecutive clocks beyond the first mismatching sample.
module pio_in_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CW'(CYCLES)) begin
      dout <= din;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pio_in_irq.sv
// Avalon-MM input port with synchroniser, edge capture, per-bit IRQ mask and
// registered level IRQ. Define PIO_IN_DEBOUNCE_EN to add per-bit debouncing.
module pio_in_irq
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] cap_clr;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_in_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (sync_in[i]),
      .dout (data_q[i])
    );
  end
  assign unused_bits = ^writedata;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= sync_in;
  end
  assign unused_bits = ^{writedata, DEBOUNCE_CYCLES[0]};
`endif

  always_comb begin
    edge_evt = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_evt = data_q & ~data_d;
      EDGE_FALL: edge_evt = ~data_q & data_d;
      EDGE_ANY:  edge_evt = data_q ^ data_d;
      default:   edge_evt = '0;
    endcase
  end

  assign wr_en   = chipselect & write;
  assign cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next[WIDTH-1:0] = data_q;
      ADDR_IRQ_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAP: rd_next[WIDTH-1:0] = edge_cap;
      default:       rd_next = '0;
    endcase
  end

  // A fresh edge overrides a same-cycle write-1-clear so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_d   <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      data_d   <= data_q;
      edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
      if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
      irq      <= |(edge_cap & irq_mask);
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_pio_in_irq.sv
// Bench for pio_in_irq: three instances (rise, fall, any) against a
// behavioural model, with directed literal checks and a random phase.
module tb_pio_in_irq;

  localparam int W    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DX = DEB;
`else
  localparam int DX = 0;
`endif
  localparam int SETTLE = SYNC + DX + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [2:0][31:0] rd_all;
  logic [2:0]    irq_all;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pio_in_irq #(
      .WIDTH(W), .SYNC_STAGES(SYNC), .EDGE_TYPE(g), .DEBOUNCE_CYCLES(DEB)
    ) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write(write), .writedata(writedata), .readdata(rd_all[g]),
      .in_port(in_port), .irq(irq_all[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]      m_pipe [SYNC];
  logic [W-1:0]      m_data, m_datad, m_mask, m_clr;
  logic [W-1:0]      m_cap  [3];
  logic [2:0][W-1:0] m_ev;
  logic [31:0]       m_rd   [3];
  logic [2:0]        m_irq;
`ifdef PIO_IN_DEBOUNCE_EN
  logic [DEB:0]      m_hist [W];
`endif

  function automatic logic [31:0] m_read(input logic [1:0] a, input int t);
    case (a)
      2'd0:    return 32'(m_data);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap[t]);
      default: return 32'h0;
    endcase
  endfunction

  always_comb begin
    m_ev    = '0;
    m_ev[0] = m_data & ~m_datad;
    m_ev[1] = ~m_data & m_datad;
    m_ev[2] = m_ev[0] | m_ev[1];
    m_clr   = (chipselect && write && address == 2'd3) ? writedata[W-1:0] : '0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < 3; t++) begin
        m_cap[t] <= '0;
        m_rd[t]  <= '0;
      end
      m_irq   <= '0;
      m_mask  <= '0;
      m_data  <= '0;
      m_datad <= '0;
      for (int i = 0; i < SYNC; i++) m_pipe[i] <= '0;
`ifdef PIO_IN_DEBOUNCE_EN
      for (int b = 0; b < W; b++) m_hist[b] <= '0;
`endif
    end else begin
      for (int t = 0; t < 3; t++) begin
        m_irq[t] <= |(m_cap[t] & m_mask);
        m_rd[t]  <= m_read(address, t);
        m_cap[t] <= (m_cap[t] & ~m_clr) | m_ev[t];
      end
      if (chipselect && write && address == 2'd2) m_mask <= writedata[W-1:0];
      m_datad <= m_data;
      for (int i = SYNC - 1; i > 0; i--) m_pipe[i] <= m_pipe[i-1];
      m_pipe[0] <= in_port;
`ifdef PIO_IN_DEBOUNCE_EN
      // accept a bit once the last DEB+1 synchronised samples all disagree with it
      for (int b = 0; b < W; b++) begin
        if ({m_hist[b][DEB-1:0], m_pipe[SYNC-1][b]} == {(DEB+1){~m_data[b]}})
          m_data[b] <= ~m_data[b];
        m_hist[b] <= {m_hist[b][DEB-1:0], m_pipe[SYNC-1][b]};
      end
`else
      m_data <= m_pipe[SYNC-1];
`endif
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int t = 0; t < 3; t++) begin
        chk($sformatf("readdata_e%0d", t), rd_all[t], m_rd[t]);
        chk($sformatf("irq_e%0d", t), 32'(irq_all[t]), 32'(m_irq[t]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    @(negedge clk);
  endtask

  initial begin
    #1 reset = 1'b1;
    in_port = 4'b1010;
    cyc(3);
    reset = 1'b0;
    cyc(SETTLE);

    rd(2'd0);
    chk("p1_data_rise", rd_all[0], 32'h0000000A);
    chk("p1_data_any",  rd_all[2], 32'h0000000A);
    rd(2'd3);
    chk("p1_cap_rise", rd_all[0], 32'hA);
    chk("p1_cap_fall", rd_all[1], 32'h0);
    chk("p1_cap_any",  rd_all[2], 32'hA);
    chk("p1_irq", 32'(irq_all), 32'h0);

    wr(2'd0, 32'h5);
    rd(2'd0);
    chk("data_ro", rd_all[0], 32'hA);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1);
    chk("reserved", rd_all[0], 32'h0);

    in_port = 4'b1000;
    cyc(SETTLE);
    wr(2'd3, 32'hF);
    wr(2'd2, 32'hFFFF_FFF2);
    rd(2'd2);
    chk("mask_width", rd_all[0], 32'h2);
    in_port = 4'b1010;
    cyc(SETTLE);
    chk("p2_irq", 32'(irq_all), 32'b101);
    rd(2'd3);
    chk("p2_cap_rise", rd_all[0], 32'h2);
    chk("p2_cap_fall", rd_all[1], 32'h0);
    wr(2'd3, 32'h2);
    cyc(2);
    chk("p2_irq_clr", 32'(irq_all), 32'h0);
    rd(2'd3);
    chk("p2_cap_clr", rd_all[0], 32'h0);

    in_port = 4'b1011;
    cyc(3 + DX);
    wr(2'd3, 32'h1);
    rd(2'd3);
    chk("p3_set_wins_rise", rd_all[0], 32'h1);
    chk("p3_set_wins_any",  rd_all[2], 32'h1);
    chk("p3_fall",          rd_all[1], 32'h0);

    wr(2'd3, 32'hF);
    in_port = 4'b0011;
    cyc(SETTLE);
    rd(2'd3);
    chk("p4_fall_rise", rd_all[0], 32'h0);
    chk("p4_fall_fall", rd_all[1], 32'h8);
    chk("p4_fall_any",  rd_all[2], 32'h8);
    wr(2'd3, 32'hF);
    in_port = 4'b1011;
    cyc(SETTLE);
    rd(2'd3);
    chk("p4_rise_rise", rd_all[0], 32'h8);
    chk("p4_rise_fall", rd_all[1], 32'h0);
    chk("p4_rise_any",  rd_all[2], 32'h8);

`ifdef PIO_IN_DEBOUNCE_EN
    in_port = 4'b1010;
    cyc(SETTLE);
    wr(2'd3, 32'hF);
    in_port = 4'b1011;
    cyc(3);
    in_port = 4'b1010;
    cyc(SETTLE);
    rd(2'd0);
    chk("p5_glitch_data", rd_all[0], 32'hA);
    rd(2'd3);
    chk("p5_glitch_cap", rd_all[0], 32'h0);
    in_port = 4'b1011;
    cyc(SETTLE);
    rd(2'd0);
    chk("p5_held_data", rd_all[0], 32'hB);
`endif

    wr(2'd2, 32'hF);
    in_port = 4'h0;
    cyc(SETTLE);
    wr(2'd3, 32'hF);
    in_port = 4'hF;
    cyc(SETTLE);
    rd(2'd3);
    chk("p6_cap_any", rd_all[2], 32'hF);
    chk("p6_irq_pre", 32'(irq_all), 32'b101);
    #2 reset = 1'b1;
    #1;
    chk("p6_irq_rst", 32'(irq_all), 32'h0);
    chk("p6_rd_rst",  rd_all[2], 32'h0);
    in_port = 4'h0;
    @(negedge clk);
    reset = 1'b0;
    rd(2'd2);
    chk("p6_mask_rst", rd_all[0], 32'h0);
    rd(2'd3);
    chk("p6_cap_rst", rd_all[2], 32'h0);

    for (int n = 0; n < 3000; n++) begin
      address    = 2'($urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      write      = ($urandom_range(0, 2) == 0);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      @(negedge clk);
    end
    chipselect = 1'b0;
    write = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
